// File: rtl/light_decoder.sv
// light_decoder: recovers the 3-bit colour code from a 24-bit RGB word,
// debounces it over STABLE_CYCLES observations and flags illegal words.
module light_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [23:0]      light,
   input  logic             clear_err,
   output logic [2:0]       colour,
   output logic             colour_valid,
   output logic             changed,
   output logic             err,
   output logic [CNT_W-1:0] change_count
);

   localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

   logic [23:0] light_q;
   logic [2:0]  cand;
   logic [3:0]  stab_cnt;
   logic [2:0]  code;
   logic        legal;
   logic [3:0]  next_cnt;
   logic        commit;

   always_comb begin
      legal = 1'b1;
      code  = 3'd0;
      case (light_q)
         24'h000000: code = 3'd0;
         24'h0000ff: code = 3'd1;
         24'h00ff00: code = 3'd2;
         24'h00ffff: code = 3'd3;
         24'hff0000: code = 3'd4;
         24'hff00ff: code = 3'd5;
         24'hffff00: code = 3'd6;
         24'hffffff: code = 3'd7;
         default:    legal = 1'b0;
      endcase
   end

   // a zero count means the last observation was illegal or nothing seen yet
   always_comb begin
      next_cnt = 4'd1;
      if (code == cand && stab_cnt != 4'd0) begin
         if (stab_cnt >= STAB)
            next_cnt = STAB;
         else
            next_cnt = stab_cnt + 4'd1;
      end
   end

   assign commit = legal && (next_cnt == STAB) &&
                   (!colour_valid || code != colour);

   always_ff @(posedge clk) begin
      if (rst) begin
         light_q      <= '0;
         cand         <= '0;
         stab_cnt     <= '0;
         colour       <= '0;
         colour_valid <= 1'b0;
         changed      <= 1'b0;
         err          <= 1'b0;
         change_count <= '0;
      end else if (enable) begin
         light_q <= light;
         changed <= commit;
         if (legal) begin
            cand     <= code;
            stab_cnt <= next_cnt;
         end else begin
            stab_cnt <= 4'd0;
         end
         if (commit) begin
            colour       <= code;
            colour_valid <= 1'b1;
            change_count <= change_count + 1'b1;
         end
         // a fresh illegal observation wins over a clear request
         if (!legal)
            err <= 1'b1;
         else if (clear_err)
            err <= 1'b0;
      end else begin
         changed <= 1'b0;
      end
   end

endmodule

// File: doc/light_decoder.md
Name: light_decoder

Overview:
- Receive-side counterpart of the colour-to-RGB path. Takes the 24-bit `light` word driven by the selector, recovers the 3-bit colour code, and filters glitches by requiring a stable value before committing.
- Reports each committed colour change and flags any RGB word that is not one of the eight legal codes.
- Sits downstream of the selector, feeding status/monitor logic and display.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical valid observations needed to commit a colour (legal range 1..15).
- CNT_W, 8, width of the committed-change counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = block advances; 0 = all state frozen
- light  input  24  RGB word, {R[23:16], G[15:8], B[7:0]}
- clear_err  input  1  clears sticky err
- colour  output  3  last committed colour code
- colour_valid  output  1  1 once any colour has been committed since reset
- changed  output  1  one-cycle pulse on the cycle colour is updated
- err  output  1  sticky: an illegal RGB word was observed
- change_count  output  CNT_W  number of commits since reset, wraps modulo 2^CNT_W

Behaviour:
- Decode table (exact match only):
  - 000000→0
  - 0000FF→1
  - 00FF00→2
  - 00FFFF→3
  - FF0000→4
  - FF00FF→5
  - FFFF00→6
  - FFFFFF→7
  - Any other word is illegal.
- Reset (rst=1 at an edge) forces the following, regardless of enable, and takes effect mid-operation:
  - light_q = 0, cand = 0, stab_cnt = 0
  - colour = 0, colour_valid = 0, changed = 0, err = 0, change_count = 0
- Stage 1: `light_q <= light` on every enabled edge.
- Stage 2 acts on every enabled edge. Let c = decode(light_q).
  - If light_q is legal:
    - Compute next_cnt = (c==cand && stab_cnt!=0) ? min(stab_cnt+1, STABLE_CYCLES) : 1.
    - Then cand <= c and stab_cnt <= next_cnt.
  - If light_q is illegal: stab_cnt <= 0, cand unchanged, err <= 1.
- Commit condition: light_q legal AND next_cnt==STABLE_CYCLES AND (colour_valid==0 OR c!=colour). On commit, in the same edge:
  - colour <= c
  - colour_valid <= 1
  - changed <= 1
  - change_count <= change_count+1
- changed is 0 on every other edge.
- Re-stabilising on the already committed colour gives no pulse and no count. stab_cnt saturates at STABLE_CYCLES.
- Latency: light changes before edge E0 and stays constant thereafter.
  - Sampled at E0; first observation at E1.
  - Commit and changed pulse at edge E(STABLE_CYCLES).
  - changed is visible for the cycle after that edge: STABLE_CYCLES+1 edges after first sampling.
- Glitch rule:
  - Any different legal word restarts the count at 1.
  - Any illegal word restarts the count at 0.
  - A glitch shorter than STABLE_CYCLES observations never reaches colour.
- enable=0: every register holds, including light_q, counters and err; changed is forced to 0. clear_err and light are ignored while disabled.
- err:
  - clear_err=1 on an enabled edge clears err.
  - If an illegal word is observed on the same edge, set wins and err stays 1.
- Post-reset: light_q=0 is a legal black (code 0) observation. If light is actually non-zero, the count restarts when the real value arrives; no spurious commit unless black persists STABLE_CYCLES observations.
- STABLE_CYCLES=1: commits on the first legal observation of a new code.
- change_count wraps from 2^CNT_W−1 to 0 without a flag.

Test Plan (STABLE_CYCLES=4, CNT_W=8):
- Reset, then hold light=0000FF with enable=1 → colour=1, colour_valid=1, changed pulses exactly once, 5 edges after the first sampling edge; change_count=1; err=0.
- After committing 1, drive FF0000 for 3 cycles then back to 0000FF → colour stays 1, no changed pulse, change_count stays 1.
- Drive 123456 for one cycle, then 00FF00 steady → err=1 after the decode edge; colour=2 commits 4 observations after the last illegal word; err stays 1. Pulse clear_err → err=0. Drive clear_err together with illegal 00FF01 → err stays 1.
- Committed 2, light=FFFF00 steady, toggle enable low for 3 cycles mid-count → commit is delayed by exactly 3 cycles; changed never asserted while enable=0; colour=6.
- Assert rst for 1 cycle while mid-count toward 7 (FFFFFF) with colour=6 committed → all outputs 0 next cycle. The FFFFFF still present then commits 7 with change_count=1.
- Alternate 0000FF/00FF00 every 4 cycles for 256 commits → change_count wraps to 0, with one changed pulse per commit.
